// File: rtl/gb_memory_bus.sv
// CPU-side memory bus: cartridge pass-through, banked WRAM, HRAM,
// SVBK bank select and the OAM DMA engine that takes over the bus.
module gb_memory_bus #(
    parameter int WRAM_BANKS = 2,
    parameter int HRAM_BYTES = 127,
    parameter int DMA_LEN    = 160,
    parameter int DMA_STRIDE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_enable,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] cart_addr,
    output logic        cart_enable,
    output logic        cart_write,
    output logic [7:0]  cart_wdata,
    input  logic [7:0]  cart_rdata,
    output logic [7:0]  oam_addr,
    output logic        oam_write,
    output logic [7:0]  oam_wdata,
    output logic        dma_active
);

    localparam int BW  = (WRAM_BANKS > 1) ? $clog2(WRAM_BANKS) : 1;
    localparam int WAW = BW + 12;
    localparam int CW  = $clog2(DMA_STRIDE);

    localparam logic [2:0]    BMASK    = 3'(WRAM_BANKS - 1);
    localparam logic [16:0]   HRAM_END = 17'h0FF80 + 17'(HRAM_BYTES);
    localparam logic [CW-1:0] C_LAST   = CW'(DMA_STRIDE - 1);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [7:0]    I_LAST   = 8'(DMA_LEN - 1);

    typedef enum logic [2:0] {
        R_NONE, R_CART, R_WRAM, R_HRAM, R_DMA, R_SVBK
    } region_t;

    typedef enum logic [1:0] {
        IDLE, START, ACTIVE
    } dma_state_t;

    region_t    region_dec;
    region_t    region_eff;
    region_t    rd_region_q;
    dma_state_t state_q;

    logic          rd_valid_q;
    logic [7:0]    hold_q;
    logic [7:0]    misc_q;
    logic [7:0]    rd_mux;
    logic [2:0]    svbk_q;
    logic [2:0]    bank_masked;
    logic [2:0]    bank_sel;
    logic [7:0]    src_q;
    logic [7:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   dma_addr;
    logic [7:0]    dma_data;
    logic [7:0]    wram_q;
    logic [7:0]    hram_q;
    logic [WAW-1:0] wram_widx;
    logic [WAW-1:0] wram_ridx;

    logic is_cart, is_wram, is_hram, is_dma, is_svbk;
    logic cpu_rd, cpu_wr;
    logic wram_we, wram_re, hram_we, hram_re;
    logic dma_wr, svbk_wr;
    logic src_cart, src_wram, dma_fetch;

    logic [7:0] wram [WRAM_BANKS*4096];
    logic [7:0] hram [HRAM_BYTES];

    // Echo space shares bit 12 semantics with C000-DFFF.
    function automatic logic [WAW-1:0] wram_index(
        input logic [12:0] a,
        input logic [2:0]  bank
    );
        logic [BW-1:0] b;
        b = a[12] ? bank[BW-1:0] : '0;
        return {b, a[11:0]};
    endfunction

    assign cpu_rd = cpu_enable & ~cpu_write;
    assign cpu_wr = cpu_enable & cpu_write;

    assign is_cart = ~cpu_addr[15] |
                     (cpu_addr[15:13] == 3'b101);
    assign is_wram = (cpu_addr[15:14] == 2'b11) &&
                     (cpu_addr < 16'hFE00);
    assign is_hram = (cpu_addr >= 16'hFF80) &&
                     ({1'b0, cpu_addr} < HRAM_END);
    assign is_dma  = (cpu_addr == 16'hFF46);
    assign is_svbk = (cpu_addr == 16'hFF70) &&
                     (WRAM_BANKS > 2);

    // Address decode into one region code.
    always_comb begin
        region_dec = R_NONE;
        unique case (1'b1)
            is_cart: region_dec = R_CART;
            is_wram: region_dec = R_WRAM;
            is_hram: region_dec = R_HRAM;
            is_dma:  region_dec = R_DMA;
            is_svbk: region_dec = R_SVBK;
            default: region_dec = R_NONE;
        endcase
    end

    // While DMA owns the bus only HRAM and the DMA register remain.
    always_comb begin
        region_eff = region_dec;
        if (dma_active &&
            region_dec != R_HRAM &&
            region_dec != R_DMA)
            region_eff = R_NONE;
    end

    assign bank_masked = svbk_q & BMASK;
    assign bank_sel    = (bank_masked == 3'd0) ? 3'd1
                                               : bank_masked;

    assign wram_we = cpu_wr && region_eff == R_WRAM;
    assign hram_we = cpu_wr && region_eff == R_HRAM;
    assign hram_re = cpu_rd && region_eff == R_HRAM;
    assign dma_wr  = cpu_wr && region_eff == R_DMA;
    assign svbk_wr = cpu_wr && region_eff == R_SVBK;

    assign src_cart = (src_q < 8'h80) ||
                      (src_q >= 8'hA0 && src_q <= 8'hBF);
    assign src_wram = (src_q >= 8'hC0);

    assign dma_addr  = {src_q, idx_q};
    assign dma_fetch = (state_q == ACTIVE) && (cnt_q == '0);

    assign wram_re = (cpu_rd && region_eff == R_WRAM) ||
                     (dma_fetch && src_wram);

    assign wram_widx = wram_index(cpu_addr[12:0], bank_sel);
    assign wram_ridx = dma_active
                     ? wram_index(dma_addr[12:0], bank_sel)
                     : wram_widx;

    assign dma_data = src_cart ? cart_rdata :
                      src_wram ? wram_q : 8'hFF;

    assign cart_addr   = dma_active ? dma_addr : cpu_addr;
    assign cart_wdata  = cpu_wdata;
    assign cart_enable = reset & (dma_active
                       ? (dma_fetch & src_cart)
                       : (cpu_enable & is_cart));
    assign cart_write  = reset & ~dma_active &
                         cpu_wr & is_cart;

    // WRAM: CPU write port, shared CPU/DMA synchronous read port.
    always_ff @(posedge clk) begin
        if (wram_we)
            wram[wram_widx] <= cpu_wdata;
        if (wram_re)
            wram_q <= wram[wram_ridx];
    end

    // HRAM: offset from FF80 is simply the low seven bits.
    always_ff @(posedge clk) begin
        if (hram_we)
            hram[cpu_addr[6:0]] <= cpu_wdata;
        if (hram_re)
            hram_q <= hram[cpu_addr[6:0]];
    end

    // SVBK bank select register.
    always_ff @(posedge clk) begin
        if (!reset)
            svbk_q <= 3'd0;
        else if (svbk_wr)
            svbk_q <= cpu_wdata[2:0];
    end

    // Register the read region so data is selected next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid_q  <= 1'b0;
            rd_region_q <= R_NONE;
            misc_q      <= 8'hFF;
        end else begin
            rd_valid_q <= cpu_rd;
            if (cpu_rd) begin
                rd_region_q <= region_eff;
                misc_q <= (region_eff == R_DMA)
                        ? src_q
                        : {5'b11111, svbk_q};
            end
        end
    end

    // Select the source for the returning read.
    always_comb begin
        rd_mux = 8'hFF;
        unique case (rd_region_q)
            R_CART:  rd_mux = cart_rdata;
            R_WRAM:  rd_mux = wram_q;
            R_HRAM:  rd_mux = hram_q;
            R_DMA:   rd_mux = misc_q;
            R_SVBK:  rd_mux = misc_q;
            default: rd_mux = 8'hFF;
        endcase
    end

    // Keep the last returned byte between reads.
    always_ff @(posedge clk) begin
        if (!reset)
            hold_q <= 8'hFF;
        else if (rd_valid_q)
            hold_q <= rd_mux;
    end

    assign cpu_rdata = rd_valid_q ? rd_mux : hold_q;

    // OAM DMA sequencer; a register write restarts from index 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            src_q      <= 8'h00;
            idx_q      <= 8'h00;
            cnt_q      <= '0;
            oam_write  <= 1'b0;
            oam_addr   <= 8'h00;
            oam_wdata  <= 8'h00;
            dma_active <= 1'b0;
        end else begin
            oam_write <= 1'b0;
            if (dma_wr) begin
                src_q      <= cpu_wdata;
                state_q    <= START;
                idx_q      <= 8'h00;
                cnt_q      <= '0;
                dma_active <= 1'b1;
            end else begin
                unique case (state_q)
                    START: begin
                        state_q <= ACTIVE;
                        idx_q   <= 8'h00;
                        cnt_q   <= '0;
                    end
                    ACTIVE: begin
                        if (cnt_q == C_ONE) begin
                            oam_write <= 1'b1;
                            oam_addr  <= idx_q;
                            oam_wdata <= dma_data;
                        end
                        if (cnt_q == C_LAST) begin
                            cnt_q <= '0;
                            idx_q <= idx_q + 8'd1;
                            if (idx_q == I_LAST) begin
                                state_q    <= IDLE;
                                dma_active <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + C_ONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
